// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life next-generation engine:
// controller state encoding and the birth/survival neighbour counts.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A dead cell with exactly BIRTH_N live neighbours becomes alive;
  // a live cell with SURVIVE_N (or BIRTH_N) live neighbours stays alive.
  localparam logic [3:0] BIRTH_N   = 4'd3;
  localparam logic [3:0] SURVIVE_N = 4'd2;

endpackage

// File: rtl/gol_row_rule.sv
// Combinational Life rule for one row: given the rows above (prev),
// the row itself (cur) and the row below (nxt), produce the next row.
// Columns outside [0, WIDTH-1] are treated as dead (no wrap-around).
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] next_row
);

  // Pad each row with a dead cell on both sides; column c sits at bit c+1.
  logic [WIDTH+1:0] p_ext;
  logic [WIDTH+1:0] c_ext;
  logic [WIDTH+1:0] n_ext;
  logic [3:0]       cnt;

  assign p_ext = {1'b0, prev, 1'b0};
  assign c_ext = {1'b0, cur,  1'b0};
  assign n_ext = {1'b0, nxt,  1'b0};

  // Count the 8 neighbours of every column and apply birth/survival.
  always_comb begin
    next_row = '0;
    cnt      = '0;
    for (int c = 0; c < WIDTH; c++) begin
      cnt = 4'(p_ext[c]) + 4'(p_ext[c+1]) + 4'(p_ext[c+2])
          + 4'(c_ext[c])                  + 4'(c_ext[c+2])
          + 4'(n_ext[c]) + 4'(n_ext[c+1]) + 4'(n_ext[c+2]);
      next_row[c] = (cnt == BIRTH_N) || (cur[c] && (cnt == SURVIVE_N));
    end
  end

endmodule

// File: rtl/gol_next_gen.sv
// Steps a 2**REGBITS x WIDTH Game-of-Life grid held in an external
// register file by one generation, updating it in place row by row.
// A three-row window (prev/cur/rd) slides down the grid; prev keeps the
// original copy of the row just overwritten so in-place writes are safe.
module gol_next_gen
  import gol_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic                            ph2,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [WIDTH-1:0]                rd,
  output logic [REGBITS-1:0]              ra,
  output logic [REGBITS-1:0]              wa,
  output logic [WIDTH-1:0]                wd,
  output logic                            regwrite,
  output logic                            busy,
  output logic                            done,
  output logic [GENBITS-1:0]              gen,
  output logic [REGBITS+$clog2(WIDTH):0]  live_count
);

  localparam int CNTW = REGBITS + $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_nx;
  logic [REGBITS-1:0] idx;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   nxt;
  logic [CNTW-1:0]    acc;
  logic               last_row;

  function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] row);
    logic [CNTW-1:0] sum;
    sum = '0;
    for (int c = 0; c < WIDTH; c++) begin
      sum = sum + CNTW'(row[c]);
    end
    return sum;
  endfunction

  assign last_row = (idx == {REGBITS{1'b1}});
  // The row below the bottom row is outside the grid and therefore dead.
  assign nxt      = last_row ? '0 : rd;

  gol_row_rule #(
    .WIDTH(WIDTH)
  ) u_rule (
    .prev     (prev),
    .cur      (cur),
    .nxt      (nxt),
    .next_row (wd)
  );

  // Next-state selection and per-state output decode.
  always_comb begin
    state_nx = state;
    ra       = '0;
    wa       = idx;
    regwrite = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        regwrite = 1'b1;
        // Wraps to 0 on the last row, where the read data is unused.
        ra       = idx + 1'b1;
        if (last_row) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Controller state, sliding row window, live-cell accumulator and counters.
  always_ff @(posedge ph2) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      prev       <= '0;
      cur        <= '0;
      acc        <= '0;
      gen        <= '0;
      live_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          cur  <= rd;
          prev <= '0;
          idx  <= '0;
          acc  <= '0;
        end
        RUN: begin
          prev <= cur;
          cur  <= rd;
          idx  <= idx + 1'b1;
          acc  <= acc + popcount(wd);
        end
        DONE: begin
          gen        <= gen + 1'b1;
          live_count <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_next_gen.sv
// Bench for gol_next_gen: an 8x8 register file around the DUT, a table of
// known patterns, randomized grids against a 2-D reference model, start
// handling, reset aborts, and generation-counter wrap on a 2-bit instance.
module tb_gol_next_gen;

  logic        ph2;
  logic        reset_n;
  logic        start;
  logic [7:0]  rd;
  logic [2:0]  ra;
  logic [2:0]  wa;
  logic [7:0]  wd;
  logic        regwrite;
  logic        busy;
  logic        done;
  logic [15:0] gen;
  logic [6:0]  live_count;

  logic        start2;
  logic [7:0]  rd2;
  logic [2:0]  ra2;
  logic [2:0]  wa2;
  logic [7:0]  wd2;
  logic        regwrite2;
  logic        busy2;
  logic        done2;
  logic [1:0]  gen2;
  logic [6:0]  live_count2;

  logic [63:0] grid;
  logic [63:0] load_val;
  logic        load_en;

  int npass  = 0;
  int ntotal = 0;
  int exp_gen = 0;

  gol_next_gen #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) dut (
    .ph2(ph2), .reset_n(reset_n), .start(start), .rd(rd), .ra(ra), .wa(wa),
    .wd(wd), .regwrite(regwrite), .busy(busy), .done(done), .gen(gen),
    .live_count(live_count)
  );

  gol_next_gen #(.WIDTH(8), .REGBITS(3), .GENBITS(2)) dut2 (
    .ph2(ph2), .reset_n(reset_n), .start(start2), .rd(rd2), .ra(ra2), .wa(wa2),
    .wd(wd2), .regwrite(regwrite2), .busy(busy2), .done(done2), .gen(gen2),
    .live_count(live_count2)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  // Register file: row r lives at grid[8r+7:8r]; combinational read port.
  assign rd  = grid[int'(ra)*8 +: 8];
  assign rd2 = 8'h00;

  // Register file write port, with a bench-side bulk load.
  always @(posedge ph2) begin
    if (load_en) grid <= load_val;
    else if (regwrite) grid[int'(wa)*8 +: 8] <= wd;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    ntotal++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference: next generation of an 8x8 grid, computed cell by cell.
  function automatic logic [63:0] life_ref(input logic [63:0] g);
    logic [63:0] r;
    int n;
    int rr;
    int cc;
    r = '0;
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 8; col++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = row + dr;
            cc = col + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (g[rr*8+cc]) n++;
          end
        end
        r[row*8+col] = (n == 3) || (g[row*8+col] && n == 2);
      end
    end
    return r;
  endfunction

  task automatic load_grid(input logic [63:0] g);
    @(negedge ph2);
    load_val = g;
    load_en  = 1'b1;
    @(posedge ph2);
    #1;
    load_en  = 1'b0;
  endtask

  // Issue a start and observe 20 cycles. Cycle n=1 is the one right after the
  // accepting edge. With hold=1 start stays high until done is seen.
  task automatic run_step(input bit hold, output int first_wr, output int nwr,
                          output int done_at, output int ndone, output int busy_bad);
    first_wr = -1; nwr = 0; done_at = -1; ndone = 0; busy_bad = 0;
    @(negedge ph2);
    start = 1'b1;
    @(posedge ph2);
    #1;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) begin
        @(posedge ph2);
        #1;
      end
      if (regwrite) begin
        nwr++;
        if (first_wr < 0) first_wr = n;
        check("write_addr", 64'(wa), 64'(n - 2));
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
        start = 1'b0;
      end
      if (busy !== (n >= 1 && n <= 9)) busy_bad++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [63:0] init;
    logic [63:0] exp_grid;
    int          live;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fw, nw, da, nd, bb;
    int got;
    logic [63:0] g, pre, mdl;
    int seq[5];

    vecs[0] = '{"blinker_h",   64'h0000_0000_1C00_0000, 64'h0000_0008_0808_0000, 3};
    vecs[1] = '{"blinker_v",   64'h0000_0008_0808_0000, 64'h0000_0000_1C00_0000, 3};
    vecs[2] = '{"block",       64'h0000_0000_0000_1818, 64'h0000_0000_0000_1818, 4};
    vecs[3] = '{"corner_blk",  64'h0000_0000_0000_0303, 64'h0000_0000_0000_0303, 4};
    vecs[4] = '{"empty",       64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 0};
    vecs[5] = '{"lone_cell",   64'h0000_0010_0000_0000, 64'h0000_0000_0000_0000, 0};
    vecs[6] = '{"bottom_full", 64'hFF00_0000_0000_0000, 64'h7E7E_0000_0000_0000, 12};

    reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    load_en = 1'b0;
    load_val = '0;
    repeat (3) @(posedge ph2);
    #1;
    check("rst_regwrite", 64'(regwrite), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_gen",      64'(gen),      64'd0);
    check("rst_live",     64'(live_count), 64'd0);
    check("rst_ra",       64'(ra),       64'd0);
    @(negedge ph2);
    reset_n = 1'b1;

    // Known patterns with hand-derived results.
    for (int v = 0; v < 7; v++) begin
      load_grid(vecs[v].init);
      run_step(1'b0, fw, nw, da, nd, bb);
      exp_gen++;
      check({vecs[v].name, "_grid"},     grid,             vecs[v].exp_grid);
      check({vecs[v].name, "_live"},     64'(live_count),  64'(vecs[v].live));
      check({vecs[v].name, "_gen"},      64'(gen),         64'(exp_gen));
      check({vecs[v].name, "_first_wr"}, 64'(fw),          64'd2);
      check({vecs[v].name, "_nwrites"},  64'(nw),          64'd8);
      check({vecs[v].name, "_done_at"},  64'(da),          64'd10);
      check({vecs[v].name, "_ndone"},    64'(nd),          64'd1);
      check({vecs[v].name, "_busy"},     64'(bb),          64'd0);
    end

    // Start held high through LOAD, RUN and DONE: only one step.
    load_grid(64'h0000_0000_1C00_0000);
    run_step(1'b1, fw, nw, da, nd, bb);
    exp_gen++;
    check("hold_nwrites", 64'(nw),  64'd8);
    check("hold_ndone",   64'(nd),  64'd1);
    check("hold_gen",     64'(gen), 64'(exp_gen));
    check("hold_grid",    grid,     64'h0000_0008_0808_0000);

    // Randomized grids against the reference model.
    for (int i = 0; i < 24; i++) begin
      g = {$urandom, $urandom};
      if (i % 3 == 1) g = g & {$urandom, $urandom};
      if (i % 3 == 2) g = g | {$urandom, $urandom};
      mdl = life_ref(g);
      load_grid(g);
      run_step(1'b0, fw, nw, da, nd, bb);
      exp_gen++;
      check("rand_grid",  grid,            mdl);
      check("rand_live",  64'(live_count), 64'($countones(mdl)));
      check("rand_gen",   64'(gen),        64'(exp_gen));
      check("rand_ndone", 64'(nd),         64'd1);
    end

    // Reset asserted during the 4th RUN cycle aborts the step.
    pre = 64'hA5C3_5A3C_F00F_9669;
    load_grid(pre);
    @(negedge ph2);
    start = 1'b1;
    @(posedge ph2);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge ph2);
      #1;
    end
    check("abort_in_run", 64'(regwrite), 64'd1);
    reset_n = 1'b0;
    @(posedge ph2);
    #1;
    check("abort_regwrite", 64'(regwrite), 64'd0);
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_gen",      64'(gen),      64'd0);
    check("abort_live",     64'(live_count), 64'd0);
    reset_n = 1'b1;
    got = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge ph2);
      #1;
      if (done || regwrite || busy) got++;
    end
    check("abort_quiet", 64'(got), 64'd0);
    check("abort_untouched_rows", 64'(grid[63:32]), 64'(pre[63:32]));
    exp_gen = 0;

    // Reset wins over a simultaneous start.
    @(negedge ph2);
    reset_n = 1'b0;
    start   = 1'b1;
    @(posedge ph2);
    #1;
    check("rst_start_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    start   = 1'b0;
    @(posedge ph2);
    #1;
    check("rst_start_idle", 64'(busy), 64'd0);

    // 2-bit generation counter wraps.
    seq = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      @(negedge ph2);
      start2 = 1'b1;
      @(posedge ph2);
      #1;
      start2 = 1'b0;
      got = 0;
      for (int n = 0; n < 30 && !got; n++) begin
        @(posedge ph2);
        #1;
        if (done2) got = 1;
      end
      check("gen2_done_seen", 64'(got), 64'd1);
      @(posedge ph2);
      #1;
      check("gen2_value", 64'(gen2), 64'(seq[k]));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
